// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared defaults and source-select type for the writeback stage
//
// Purpose: default widths/counts for reg_writeback and the enum naming which
//          result source (none / ALU / load unit) is accepted in a cycle.
// Ports:   none (package).
package wb_pkg;

  localparam int WB_DATA_WIDTH  = 32;
  localparam int WB_REG_NUM     = 32;
  localparam int WB_REG_NUM_BIT = 5;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending-write scoreboard for register hazard queries
//
// Purpose: one pending bit per register. Issue sets a bit, commit clears it,
//          and a set wins over a clear of the same index at the same edge.
//          Register 0 is never marked pending and always reads not busy.
// Ports:   clk, rst_n             clock, async active-low reset
//          set_en / set_idx       mark register as having an uncommitted write
//          clr_en / clr_idx       register-file commit of that register
//          rs1_idx / rs2_idx      query indices
//          rs1_busy / rs2_busy    combinational query results
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int REG_NUM     = WB_REG_NUM,
  parameter int REG_NUM_BIT = WB_REG_NUM_BIT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   set_en,
  input  logic [REG_NUM_BIT-1:0] set_idx,
  input  logic                   clr_en,
  input  logic [REG_NUM_BIT-1:0] clr_idx,
  input  logic [REG_NUM_BIT-1:0] rs1_idx,
  input  logic [REG_NUM_BIT-1:0] rs2_idx,
  output logic                   rs1_busy,
  output logic                   rs2_busy
);

  logic [REG_NUM-1:0] pending;
  logic [REG_NUM-1:0] pending_nxt;

  // Clear first, then set, so a same-edge set of the same index survives.
  always_comb begin
    pending_nxt = pending;
    if (clr_en) begin
      pending_nxt[clr_idx] = 1'b0;
    end
    if (set_en && (set_idx != '0)) begin
      pending_nxt[set_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  assign rs1_busy = (rs1_idx != '0) && pending[rs1_idx];
  assign rs2_busy = (rs2_idx != '0) && pending[rs2_idx];

endmodule

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - ALU/load result arbitration into the register-file write port
//
// Purpose: accepts at most one result per cycle (load unit has fixed priority),
//          registers it onto the register-file write port one cycle later, and
//          tracks outstanding destination writes for hazard queries.
// Ports:   clk, rst_n                       clock, async active-low reset
//          alu_valid/alu_ready/alu_rd/alu_data   ALU result stream
//          lsu_valid/lsu_ready/lsu_rd/lsu_data   load result stream
//          issue_valid/issue_rd             issued instruction's destination
//          rs1_idx/rs2_idx, rs1_busy/rs2_busy    hazard queries
//          rf_wen/rf_waddr/rf_wdata         registered register-file write port
// Option:  WB_PERF_EN adds alu_wb_cnt, lsu_wb_cnt, alu_stall_cnt (32-bit, wrapping).
module reg_writeback
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH  = WB_DATA_WIDTH,
  parameter int REG_NUM     = WB_REG_NUM,
  parameter int REG_NUM_BIT = WB_REG_NUM_BIT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [REG_NUM_BIT-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]  alu_data,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [REG_NUM_BIT-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0]  lsu_data,
  input  logic                   issue_valid,
  input  logic [REG_NUM_BIT-1:0] issue_rd,
  input  logic [REG_NUM_BIT-1:0] rs1_idx,
  input  logic [REG_NUM_BIT-1:0] rs2_idx,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic                   rf_wen,
  output logic [REG_NUM_BIT-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]  rf_wdata
`ifdef WB_PERF_EN
  ,
  output logic [31:0]            alu_wb_cnt,
  output logic [31:0]            lsu_wb_cnt,
  output logic [31:0]            alu_stall_cnt
`endif
);

  // Goes high at the first edge after reset release, so nothing can be
  // accepted at that edge and no write appears in the following cycle.
  logic                   run;
  wb_src_e                src;
  logic [REG_NUM_BIT-1:0] sel_rd;
  logic [DATA_WIDTH-1:0]  sel_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  assign lsu_ready = run;
  assign alu_ready = run & ~lsu_valid;

  always_comb begin
    src      = SRC_NONE;
    sel_rd   = '0;
    sel_data = '0;
    if (lsu_valid && lsu_ready) begin
      src      = SRC_LSU;
      sel_rd   = lsu_rd;
      sel_data = lsu_data;
    end else if (alu_valid && alu_ready) begin
      src      = SRC_ALU;
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end
  end

  // Writes to x0 are consumed but never reach the port; address/data only
  // move on a real write and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= (src != SRC_NONE) && (sel_rd != '0);
      if ((src != SRC_NONE) && (sel_rd != '0)) begin
        rf_waddr <= sel_rd;
        rf_wdata <= sel_data;
      end
    end
  end

  // Pending bits clear on commit (rf_wen), not when the result is accepted.
  wb_scoreboard #(
    .REG_NUM     (REG_NUM),
    .REG_NUM_BIT (REG_NUM_BIT)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue_valid),
    .set_idx  (issue_rd),
    .clr_en   (rf_wen),
    .clr_idx  (rf_waddr),
    .rs1_idx  (rs1_idx),
    .rs2_idx  (rs2_idx),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

`ifdef WB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_wb_cnt    <= '0;
      lsu_wb_cnt    <= '0;
      alu_stall_cnt <= '0;
    end else begin
      if (src == SRC_ALU) begin
        alu_wb_cnt <= alu_wb_cnt + 32'd1;
      end
      if (src == SRC_LSU) begin
        lsu_wb_cnt <= lsu_wb_cnt + 32'd1;
      end
      if (alu_valid && !alu_ready) begin
        alu_stall_cnt <= alu_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - self-checking bench for reg_writeback
//
// Purpose: random and directed stimulus compared each cycle against a
//          behavioural model of the writeback rules.
// Ports:   none (top-level bench). Honours WB_PERF_EN if defined.
module tb_reg_writeback;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, lsu_valid, issue_valid;
  logic        alu_ready, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, issue_rd, rs1_idx, rs2_idx;
  logic [31:0] alu_data, lsu_data;
  logic        rs1_busy, rs2_busy;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef WB_PERF_EN
  logic [31:0] alu_wb_cnt, lsu_wb_cnt, alu_stall_cnt;
`endif

  reg_writeback dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_idx     (rs1_idx),
    .rs2_idx     (rs2_idx),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
`ifdef WB_PERF_EN
    ,
    .alu_wb_cnt    (alu_wb_cnt),
    .lsu_wb_cnt    (lsu_wb_cnt),
    .alu_stall_cnt (alu_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit        m_run;
  bit        m_wen;
  bit [4:0]  m_waddr;
  bit [31:0] m_wdata;
  bit        m_pend [32];
  bit [31:0] m_alu_cnt, m_lsu_cnt, m_stall_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_wen = 0; m_waddr = 0; m_wdata = 0;
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
    m_alu_cnt = 0; m_lsu_cnt = 0; m_stall_cnt = 0;
  endfunction

  // One clock edge of the writeback rules, using the inputs present at the edge.
  function automatic void model_edge();
    bit        take_lsu, take_alu;
    bit [4:0]  rd;
    bit [31:0] data;
    take_lsu = m_run && lsu_valid;
    take_alu = m_run && !lsu_valid && alu_valid;
    rd   = take_lsu ? lsu_rd : alu_rd;
    data = take_lsu ? lsu_data : alu_data;
    if (alu_valid && !(m_run && !lsu_valid)) m_stall_cnt++;
    if (take_alu) m_alu_cnt++;
    if (take_lsu) m_lsu_cnt++;
    // commit of the write currently on the port, then any new issue
    if (m_wen) m_pend[m_waddr] = 0;
    if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1;
    m_wen = (take_lsu || take_alu) && rd != 0;
    if (m_wen) begin
      m_waddr = rd;
      m_wdata = data;
    end
    m_run = 1;
  endfunction

  function automatic bit exp_busy(input bit [4:0] idx);
    return (idx != 0) && m_pend[idx];
  endfunction

  // Called just after a negedge, with inputs for the coming edge already applied.
  task automatic probe();
    #1;
    check("rf_wen",    rf_wen,    m_wen);
    check("rf_waddr",  rf_waddr,  m_waddr);
    check("rf_wdata",  rf_wdata,  m_wdata);
    check("lsu_ready", lsu_ready, m_run);
    check("alu_ready", alu_ready, m_run && !lsu_valid);
    check("rs1_busy",  rs1_busy,  exp_busy(rs1_idx));
    check("rs2_busy",  rs2_busy,  exp_busy(rs2_idx));
`ifdef WB_PERF_EN
    check("alu_wb_cnt",    alu_wb_cnt,    m_alu_cnt);
    check("lsu_wb_cnt",    lsu_wb_cnt,    m_lsu_cnt);
    check("alu_stall_cnt", alu_stall_cnt, m_stall_cnt);
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    alu_valid = 0; lsu_valid = 0; issue_valid = 0;
  endtask

  initial begin
    rst_n = 0;
    idle();
    alu_rd = 0; lsu_rd = 0; issue_rd = 0; rs1_idx = 0; rs2_idx = 0;
    alu_data = 0; lsu_data = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    lsu_valid = 1; alu_valid = 1; alu_rd = 6; lsu_rd = 2;
    probe();                                    // reset state
    rst_n = 1;
    probe();
    advance();                                  // deassertion edge: nothing accepted
    probe();
    check("no_write_after_release", rf_wen, 1'b0);
    idle();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      lsu_valid   = ($urandom_range(0, 3) == 0);
      alu_valid   = $urandom_range(0, 1);
      issue_valid = ($urandom_range(0, 2) == 0);
      alu_rd   = $urandom_range(0, 15);
      lsu_rd   = $urandom_range(0, 15);
      issue_rd = $urandom_range(0, 15);
      rs1_idx  = $urandom_range(0, 15);
      rs2_idx  = $urandom_range(0, 15);
      alu_data = $urandom;
      lsu_data = $urandom;
      probe();
      advance();
    end
    idle();
    probe();
    advance();

    // single ALU write
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    probe(); advance();
    idle();
    probe();
    check("alu_wen",   rf_wen,   1'b1);
    check("alu_waddr", rf_waddr, 5'd5);
    check("alu_wdata", rf_wdata, 32'hDEADBEEF);
    advance();
    probe();
    check("alu_wen_off", rf_wen, 1'b0);

    // collision: load unit wins, ALU follows
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h11;
    probe();
    check("coll_alu_ready", alu_ready, 1'b0);
    advance();
    lsu_valid = 0;
    probe();
    check("coll_alu_ready2", alu_ready, 1'b1);
    check("coll_waddr1", rf_waddr, 5'd4);
    check("coll_wdata1", rf_wdata, 32'h11);
    advance();
    idle();
    probe();
    check("coll_wen2",   rf_wen,   1'b1);
    check("coll_waddr2", rf_waddr, 5'd3);
    advance();

    // scoreboard clears at commit, not at acceptance
    issue_valid = 1; issue_rd = 7; rs1_idx = 7;
    probe(); advance();
    issue_valid = 0;
    probe();
    check("sb_busy_issue", rs1_busy, 1'b1);
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    probe(); advance();
    idle();
    probe();
    check("sb_busy_wen", rs1_busy, 1'b1);
    advance();
    probe();
    check("sb_busy_commit", rs1_busy, 1'b0);

    // same-edge set and clear
    issue_valid = 1; issue_rd = 9; rs2_idx = 9;
    probe(); advance();
    issue_valid = 0; alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    probe(); advance();
    alu_valid = 0; issue_valid = 1; issue_rd = 9;
    probe(); advance();
    idle();
    probe();
    check("same_edge_busy", rs2_busy, 1'b1);

    // x0 handling
    issue_valid = 1; issue_rd = 0; lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hFFFF; rs1_idx = 0;
    probe();
    check("x0_lsu_ready", lsu_ready, 1'b1);
    advance();
    idle();
    probe();
    check("x0_wen",  rf_wen,   1'b0);
    check("x0_busy", rs1_busy, 1'b0);

    // reset mid-operation
    issue_valid = 1; issue_rd = 12; rs1_idx = 12;
    probe(); advance();
    issue_valid = 0; alu_valid = 1; alu_rd = 12; alu_data = 32'hC0C0;
    probe(); advance();
    probe();
    check("pre_rst_wen",  rf_wen,   1'b1);
    check("pre_rst_busy", rs1_busy, 1'b1);
    lsu_valid = 1; lsu_rd = 13;
    rst_n = 0;
    model_reset();
    probe();
    check("rst_wen",  rf_wen,   1'b0);
    check("rst_busy", rs1_busy, 1'b0);
`ifdef WB_PERF_EN
    check("rst_cnt", alu_wb_cnt | lsu_wb_cnt | alu_stall_cnt, 32'd0);
`endif
    advance();
    rst_n = 1;
    probe(); advance();
    probe();
    check("rst_release_wen", rf_wen, 1'b0);
    advance();
    idle();
    probe();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
